protocol_controller: RTL and testbench

USB bulk-endpoint protocol controller FSM. It sits between the RX packet decoder, the TX packet encoder and the shared data buffer. It decides whether host OUT data is accepted (ACK) or refused (NAK), and whether host IN requests are served with data or NAKed. It also drives the buffer direction, clear and the transfer-status flags.

---
 rtl/protocol_controller.sv | 110 +++++++++++
 tb/tb_protocol_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/protocol_controller.sv
// USB bulk-endpoint protocol controller: decides ACK/NAK for host OUT data and
// serves or NAKs host IN requests, driving buffer direction, clear and status flags.
module protocol_controller (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [6:0] Buffer_Occupancy,
  input  logic [6:0] TX_Packet_Data_Size,
  input  logic       Buffer_Reserved,
  input  logic [2:0] RX_Packet,
  output logic       RX_Error,
  output logic       RX_Transfer_Active,
  output logic       RX_Data_Ready,
  output logic       TX_Transfer_Active,
  output logic       TX_Error,
  output logic       D_Mode,
  output logic [1:0] TX_Packet,
  output logic       clear
);

  // state    | meaning
  // IDLE     | waiting for a token
  // OUT_MODE | receiving OUT data into an empty buffer
  // OUT_WAIT | OUT refused or aborted; draining until the DATA packet ends
  // OUT_ACK  | OUT data accepted, ACK sent
  // OUT_NAK  | OUT data refused, NAK sent
  // IN_MODE  | sending IN data until host ACK
  // IN_NAK   | IN request refused, NAK sent
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OUT_MODE = 3'd1,
    OUT_WAIT = 3'd2,
    OUT_ACK  = 3'd3,
    OUT_NAK  = 3'd4,
    IN_MODE  = 3'd5,
    IN_NAK   = 3'd6
  } state_t;

  localparam logic [2:0] RX_IN   = 3'b001;
  localparam logic [2:0] RX_OUT  = 3'b010;
  localparam logic [2:0] RX_ACK  = 3'b011;
  localparam logic [2:0] RX_ERR  = 3'b100;
  localparam logic [2:0] RX_DATA = 3'b101;

  localparam logic [1:0] TXP_NONE = 2'b00;
  localparam logic [1:0] TXP_DATA = 2'b01;
  localparam logic [1:0] TXP_NAK  = 2'b10;
  localparam logic [1:0] TXP_ACK  = 2'b11;

  // {RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active,
  //  TX_Error, D_Mode, TX_Packet[1:0], clear}
  typedef logic [8:0] outs_t;

  state_t state_q, state_d;
  outs_t  outs_q, outs_d;

  logic in_ok;
  assign in_ok = !Buffer_Reserved && (TX_Packet_Data_Size != 7'd0) &&
                 (Buffer_Occupancy >= TX_Packet_Data_Size);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (RX_Packet == RX_OUT)
          state_d = (Buffer_Occupancy == 7'd0 && !Buffer_Reserved) ? OUT_MODE : OUT_WAIT;
        else if (RX_Packet == RX_IN)
          state_d = in_ok ? IN_MODE : IN_NAK;
      end
      OUT_MODE: begin
        if (RX_Packet == RX_DATA)     state_d = OUT_ACK;
        else if (RX_Packet == RX_ERR) state_d = OUT_WAIT;
      end
      OUT_WAIT: if (RX_Packet == RX_DATA) state_d = OUT_NAK;
      OUT_ACK:  state_d = IDLE;
      OUT_NAK:  state_d = IDLE;
      IN_MODE:  if (RX_Packet == RX_ACK) state_d = IDLE;
      IN_NAK:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they remain a pure function of the current state with no output glitches.
  always_comb begin
    outs_d = '0;
    unique case (state_d)
      OUT_MODE: outs_d = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, TXP_NONE, 1'b0};
      OUT_WAIT: outs_d = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, TXP_NONE, 1'b1};
      OUT_ACK:  outs_d = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, TXP_ACK,  1'b0};
      OUT_NAK:  outs_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TXP_NAK,  1'b1};
      IN_MODE:  outs_d = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TXP_DATA, 1'b0};
      IN_NAK:   outs_d = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, TXP_NAK,  1'b1};
      default:  outs_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

  assign {RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active,
          TX_Error, D_Mode, TX_Packet, clear} = outs_q;

endmodule

// File: tb/tb_protocol_controller.sv
// Directed testbench for protocol_controller; each task drives one scenario
// and compares the packed output vector against hand-computed values.
module tb_protocol_controller;

  logic       clk;
  logic       n_rst;
  logic [6:0] Buffer_Occupancy;
  logic [6:0] TX_Packet_Data_Size;
  logic       Buffer_Reserved;
  logic [2:0] RX_Packet;
  logic       RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active;
  logic       TX_Error, D_Mode, clear;
  logic [1:0] TX_Packet;

  int checks = 0;
  int errors = 0;

  // {RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active, TX_Error, D_Mode, TX_Packet, clear}
  logic [8:0] obs;
  assign obs = {RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active,
                TX_Error, D_Mode, TX_Packet, clear};

  localparam logic [8:0] E_IDLE  = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] E_OUTM  = 9'b0_1_0_0_0_1_00_0;
  localparam logic [8:0] E_OUTW  = 9'b0_1_0_0_0_1_00_1;
  localparam logic [8:0] E_OACK  = 9'b0_0_1_0_0_0_11_0;
  localparam logic [8:0] E_ONAK  = 9'b1_0_0_0_0_0_10_1;
  localparam logic [8:0] E_INM   = 9'b0_0_0_1_0_0_01_0;
  localparam logic [8:0] E_INNAK = 9'b0_0_0_0_1_0_10_1;

  protocol_controller dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .Buffer_Occupancy    (Buffer_Occupancy),
    .TX_Packet_Data_Size (TX_Packet_Data_Size),
    .Buffer_Reserved     (Buffer_Reserved),
    .RX_Packet           (RX_Packet),
    .RX_Error            (RX_Error),
    .RX_Transfer_Active  (RX_Transfer_Active),
    .RX_Data_Ready       (RX_Data_Ready),
    .TX_Transfer_Active  (TX_Transfer_Active),
    .TX_Error            (TX_Error),
    .D_Mode              (D_Mode),
    .TX_Packet           (TX_Packet),
    .clear               (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; RX_Packet = 3'b000; Buffer_Occupancy = 7'd0;
    TX_Packet_Data_Size = 7'd0; Buffer_Reserved = 1'b0;
    tick(); tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL reset_held: got %b expected %b", obs, E_IDLE); end
    n_rst = 1'b1;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL reset_released: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_out_accept();
    Buffer_Occupancy = 7'd0; Buffer_Reserved = 1'b0; RX_Packet = 3'b010;
    tick();
    checks++; if (obs !== E_OUTM) begin errors++; $display("FAIL out_accept_mode: got %b expected %b", obs, E_OUTM); end
    RX_Packet = 3'b000; Buffer_Occupancy = 7'd5;
    tick();
    checks++; if (obs !== E_OUTM) begin errors++; $display("FAIL out_accept_occ_ignored: got %b expected %b", obs, E_OUTM); end
    RX_Packet = 3'b101;
    tick();
    checks++; if (obs !== E_OACK) begin errors++; $display("FAIL out_accept_ack: got %b expected %b", obs, E_OACK); end
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL out_accept_idle: got %b expected %b", obs, E_IDLE); end
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL idle_ignores_data: got %b expected %b", obs, E_IDLE); end
    RX_Packet = 3'b011;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL idle_ignores_ack: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_out_refuse();
    Buffer_Occupancy = 7'd1; RX_Packet = 3'b010;
    tick();
    checks++; if (obs !== E_OUTW) begin errors++; $display("FAIL out_refuse_wait: got %b expected %b", obs, E_OUTW); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_OUTW) begin errors++; $display("FAIL out_refuse_wait_hold: got %b expected %b", obs, E_OUTW); end
    RX_Packet = 3'b101;
    tick();
    checks++; if (obs !== E_ONAK) begin errors++; $display("FAIL out_refuse_nak: got %b expected %b", obs, E_ONAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL out_refuse_idle: got %b expected %b", obs, E_IDLE); end
    Buffer_Occupancy = 7'd0; Buffer_Reserved = 1'b1; RX_Packet = 3'b010;
    tick();
    checks++; if (obs !== E_OUTW) begin errors++; $display("FAIL out_reserved_wait: got %b expected %b", obs, E_OUTW); end
    Buffer_Reserved = 1'b0; RX_Packet = 3'b101;
    tick();
    checks++; if (obs !== E_ONAK) begin errors++; $display("FAIL out_reserved_nak: got %b expected %b", obs, E_ONAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL out_reserved_idle: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_out_error();
    Buffer_Occupancy = 7'd0; Buffer_Reserved = 1'b0; RX_Packet = 3'b010;
    tick();
    checks++; if (obs !== E_OUTM) begin errors++; $display("FAIL out_err_mode: got %b expected %b", obs, E_OUTM); end
    RX_Packet = 3'b100;
    tick();
    checks++; if (obs !== E_OUTW) begin errors++; $display("FAIL out_err_wait: got %b expected %b", obs, E_OUTW); end
    RX_Packet = 3'b101;
    tick();
    checks++; if (obs !== E_ONAK) begin errors++; $display("FAIL out_err_nak: got %b expected %b", obs, E_ONAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL out_err_idle: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_in_served();
    Buffer_Reserved = 1'b1; RX_Packet = 3'b000;
    tick();
    Buffer_Reserved = 1'b0; Buffer_Occupancy = 7'd64; TX_Packet_Data_Size = 7'd64; RX_Packet = 3'b001;
    tick();
    checks++; if (obs !== E_INM) begin errors++; $display("FAIL in_served_mode: got %b expected %b", obs, E_INM); end
    Buffer_Reserved = 1'b1;
    tick();
    checks++; if (obs !== E_INM) begin errors++; $display("FAIL in_served_hold: got %b expected %b", obs, E_INM); end
    Buffer_Reserved = 1'b0; RX_Packet = 3'b011;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL in_served_ack_idle: got %b expected %b", obs, E_IDLE); end
    Buffer_Occupancy = 7'd5; TX_Packet_Data_Size = 7'd5; RX_Packet = 3'b001;
    tick();
    checks++; if (obs !== E_INM) begin errors++; $display("FAIL in_equal_size: got %b expected %b", obs, E_INM); end
    RX_Packet = 3'b011;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL in_equal_idle: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_in_refused();
    Buffer_Occupancy = 7'd0; TX_Packet_Data_Size = 7'd0; RX_Packet = 3'b001;
    tick();
    checks++; if (obs !== E_INNAK) begin errors++; $display("FAIL in_nak_empty: got %b expected %b", obs, E_INNAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL in_nak_empty_idle: got %b expected %b", obs, E_IDLE); end
    Buffer_Reserved = 1'b1; Buffer_Occupancy = 7'd1; TX_Packet_Data_Size = 7'd1; RX_Packet = 3'b001;
    tick();
    checks++; if (obs !== E_INNAK) begin errors++; $display("FAIL in_nak_reserved: got %b expected %b", obs, E_INNAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL in_nak_reserved_idle: got %b expected %b", obs, E_IDLE); end
    Buffer_Reserved = 1'b0; Buffer_Occupancy = 7'd4; TX_Packet_Data_Size = 7'd5; RX_Packet = 3'b001;
    tick();
    checks++; if (obs !== E_INNAK) begin errors++; $display("FAIL in_nak_short: got %b expected %b", obs, E_INNAK); end
    RX_Packet = 3'b000;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL in_nak_short_idle: got %b expected %b", obs, E_IDLE); end
  endtask

  task automatic test_async_reset();
    Buffer_Occupancy = 7'd0; Buffer_Reserved = 1'b0; RX_Packet = 3'b010;
    tick();
    checks++; if (obs !== E_OUTM) begin errors++; $display("FAIL async_pre_mode: got %b expected %b", obs, E_OUTM); end
    RX_Packet = 3'b000;
    #2 n_rst = 1'b0;
    #1;
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL async_reset_immediate: got %b expected %b", obs, E_IDLE); end
    #3 n_rst = 1'b1;
    RX_Packet = 3'b101;
    tick();
    checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL async_reset_idle: got %b expected %b", obs, E_IDLE); end
    RX_Packet = 3'b000;
  endtask

  initial begin
    test_reset();
    test_out_accept();
    test_out_refuse();
    test_out_error();
    test_in_served();
    test_in_refused();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
